// File: rtl/data_router_pkg.sv
// Shared types and defaults for the data-router row shift sequencer.
// Optional feature macro used by row_shift_sched: ROW_SHIFT_SCHED_OVERLAP_EN.
package data_router_pkg;

  // Default window depth, matching the shift-buffer depth.
  localparam int unsigned RowSchedStride = 2;
  // Default row-counter width; the tallest layer is 2**RowSchedRw - 1 rows.
  localparam int unsigned RowSchedRw     = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } row_sched_state_e;

endpackage

// File: rtl/row_down_counter.sv
// Loadable down-counter with a zero flag, used to track rows left in a layer.
// Decrements saturate at zero, so the count can never wrap.
module row_down_counter
  import data_router_pkg::*;
#(
  parameter int unsigned RW = RowSchedRw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [RW-1:0] load_val,
  input  logic          dec,
  output logic [RW-1:0] count,
  output logic          zero
);

  logic [RW-1:0] count_q;

  // Load wins over decrement; a decrement at zero is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && !zero) begin
      count_q <= count_q - RW'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/row_shift_sched.sv
// Row shift-buffer sequencer: accepts rows from the line reader, strobes the
// shift buffer once per accepted row and presents a window to the PE array
// once STRIDE rows (or the layer remainder) are resident.
// Optional macro ROW_SHIFT_SCHED_OVERLAP_EN selects sliding-window mode, where
// only one new row is shifted in for each window after the first.
module row_shift_sched
  import data_router_pkg::*;
#(
  parameter int unsigned STRIDE = RowSchedStride,
  parameter int unsigned RW     = RowSchedRw,
  localparam int unsigned CW    = $clog2(STRIDE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic [RW-1:0] cfg_rows,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          fifo_read,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [CW-1:0] out_rows,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] StrideCnt = CW'(STRIDE);

`ifdef ROW_SHIFT_SCHED_OVERLAP_EN
  // Keep STRIDE-1 rows resident so each later window needs one fresh row.
  localparam logic [CW-1:0] RefillCnt = CW'(STRIDE - 1);
`else
  localparam logic [CW-1:0] RefillCnt = '0;
`endif

  row_sched_state_e state_q;
  logic [CW-1:0]    fill_cnt_q;
  logic [CW-1:0]    fill_cnt_inc;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [CW-1:0]    out_rows_q;
  logic             busy_q;
  logic             done_q;

  logic [RW-1:0]    rows_left;
  logic             rows_zero;
  logic             rows_load;
  logic             last_row;

  // in_ready_q is only ever high in FILL, so in_valid is ignored elsewhere.
  assign fifo_read    = in_valid & in_ready_q;
  assign rows_load    = (state_q == IDLE) && cfg_start && (cfg_rows != '0);
  assign fill_cnt_inc = fill_cnt_q + CW'(1);
  // The row being accepted now is the final row of the layer.
  assign last_row     = (rows_left == RW'(1));

  row_down_counter #(
    .RW (RW)
  ) u_rows_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rows_load),
    .load_val (cfg_rows),
    .dec      (fifo_read),
    .count    (rows_left),
    .zero     (rows_zero)
  );

  // Control FSM with all handshake/status outputs registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_rows_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_rows != '0) begin
              fill_cnt_q <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= FILL;
            end else begin
              // Empty layer: acknowledge immediately without leaving IDLE.
              done_q <= 1'b1;
            end
          end
        end

        FILL: begin
          if (fifo_read) begin
            fill_cnt_q <= fill_cnt_inc;
            if ((fill_cnt_inc == StrideCnt) || last_row) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_rows_q  <= fill_cnt_inc;
              out_last_q  <= last_row;
              state_q     <= HOLD;
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_rows_q  <= '0;
            if (rows_zero) begin
              fill_cnt_q <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end else begin
              fill_cnt_q <= RefillCnt;
              in_ready_q <= 1'b1;
              state_q    <= FILL;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_rows  = out_rows_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifndef SYNTHESIS
  // The buffer must stay frozen while a window is presented.
  a_no_shift_in_hold : assert property (
    @(posedge clk) disable iff (!rst_n) out_valid |-> !fifo_read);

  // A stalled window keeps its qualifiers until it is taken.
  a_window_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_rows) && $stable(out_last)));

  // A presented window always carries 1..STRIDE fresh rows.
  a_rows_range : assert property (
    @(posedge clk) disable iff (!rst_n)
    out_valid |-> ((out_rows != '0) && (out_rows <= StrideCnt)));
`endif

endmodule

// File: doc/row_shift_sched.md
Name: row_shift_sched

Overview:
- Sequencer for the data-router row shift buffer (the STRIDE-deep, BUFW-wide shift register driven by a single fifo_read strobe).
- Accepts a row stream from the feature-map reader with a valid/ready handshake, and issues one fifo_read per accepted row.
- Declares a window valid to the PE array once STRIDE rows are resident, holds the buffer stable until the window is consumed, and tracks rows remaining per layer.
- Sits between the line reader and the shift buffer in the data_router.

Parameters:
- STRIDE, 2: rows per window; matches the shift-buffer depth; legal values are 1 or greater.
- RW, 10: width of the row counter; maximum layer height is 2^RW-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  single-cycle pulse that begins a layer; sampled only in IDLE
- cfg_rows  in  RW  input rows in the layer; sampled with cfg_start; 0 is treated as a no-op
- in_valid  in  1  upstream row available
- in_ready  out  1  controller accepts a row this cycle
- fifo_read  out  1  shift strobe to the buffer; equals in_valid & in_ready
- out_valid  out  1  buffer holds a complete window
- out_ready  in  1  downstream consumes the window
- out_last  out  1  qualifies out_valid; marks the final window of the layer
- out_rows  out  $clog2(STRIDE+1)  number of fresh rows in the current window, 1..STRIDE
- busy  out  1  high whenever the state is not IDLE
- done  out  1  single-cycle pulse after the last window is consumed

Behaviour:
- Reset values: all outputs 0; state IDLE; counters cleared.
- Asynchronous reset mid-layer aborts the layer. Buffer contents are not cleared (the buffer has no reset); the next layer overwrites them.
- States:
  - IDLE
    - cfg_start with cfg_rows != 0: latch rows_left = cfg_rows, fill_cnt = 0, go to FILL.
    - cfg_start with cfg_rows == 0: pulse done next cycle, stay IDLE.
  - FILL
    - in_ready = 1.
    - On accept: fifo_read = 1, fill_cnt++, rows_left--.
    - When the accept makes fill_cnt == STRIDE or rows_left == 0, go to HOLD on the next edge.
  - HOLD
    - in_ready = 0, fifo_read = 0, out_valid = 1.
    - out_rows = fill_cnt.
    - out_last = (rows_left == 0).
    - On out_ready:
      - if out_last: go to IDLE, done pulses for 1 cycle.
      - else: fill_cnt = 0, go to FILL.
- Window latency: the first out_valid occurs 1 cycle after the edge that accepts the STRIDE-th row, i.e. after STRIDE accepts plus 1 registered cycle.
- Partial last window (cfg_rows % STRIDE != 0):
  - Emitted with out_rows = remainder and out_last = 1.
  - Stale rows in the lower buffer slots are the consumer's responsibility to mask using out_rows.
- out_valid is held until out_ready (AXI-style); out_last and out_rows are stable while out_valid is high.
- fifo_read never asserts in HOLD, so the buffer is frozen while a window is presented.
- cfg_start while busy is ignored; no error is flagged.
- in_valid is never looked at outside FILL.
- rows_left uses RW-bit unsigned arithmetic and never underflows, because accepts stop at 0.
- STRIDE = 1: every accepted row produces a window; FILL→HOLD on every accept.

Optional Feature:
- Macro: ROW_SHIFT_SCHED_OVERLAP_EN
- Defined (sliding-window mode):
  - The first window needs STRIDE rows.
  - After each consumed non-last window, fill_cnt is preloaded to STRIDE-1, so only one new row is shifted in per window. out_rows reports STRIDE for these windows.
  - The layer yields cfg_rows-STRIDE+1 windows.
  - If cfg_rows < STRIDE, one partial window is produced as in the default mode.
- Undefined: non-overlapping behaviour as above.

Decomposition:
- Package data_router_pkg:
  - state enum row_sched_state_e {IDLE, FILL, HOLD}
  - default-parameter localparams
- One sub-module is natural: row_down_counter, the loadable RW-bit down-counter with decrement-enable and a zero flag, used for rows_left.
- The fill counter stays inline.

Test Plan:
- STRIDE=2, cfg_rows=4, in_valid held 1, out_ready held 1 -> fifo_read pulses 2 cycles, out_valid 1 cycle, repeated twice; second window has out_last=1; done pulses once; 2 windows total with out_rows=2.
- cfg_rows=5, STRIDE=2 -> 3 windows; the last has out_rows=1 and out_last=1; exactly 5 fifo_read pulses.
- Backpressure: out_ready low for 10 cycles in HOLD -> out_valid stays high, in_ready and fifo_read stay 0, window outputs stable.
- Upstream bubbles: in_valid toggling 1,0,1 -> fifo_read only on valid cycles; window after the 2nd accepted row.
- rst_n asserted mid-FILL with 1 row accepted -> outputs 0 immediately; a new cfg_start with cfg_rows=2 produces one clean window.
- OVERLAP_EN, STRIDE=3, cfg_rows=5 -> 3 windows; fifo_read counts of 3, 1, 1; out_last on the 3rd; cfg_start during busy is ignored.
